// File: rtl/msg_tx_scheduler_pkg.sv
// Shared FIX transmit definitions: host address width, scheduler states and
// outbound message-type codes.
`ifndef HOST_ADDR_WIDTH
`define HOST_ADDR_WIDTH 8
`endif

package msg_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_t;

    localparam logic [3:0] MSG_INVALID    = 4'h0;
    localparam logic [3:0] MSG_LOGON      = 4'h1;
    localparam logic [3:0] MSG_HEARTBEAT  = 4'h2;
    localparam logic [3:0] MSG_TEST_REQ   = 4'h3;
    localparam logic [3:0] MSG_LOGOUT     = 4'h4;
    localparam logic [3:0] MSG_RESEND_REQ = 4'h5;

    function automatic logic msg_is_valid(input logic [3:0] t);
        return t != MSG_INVALID;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx
);

    localparam int unsigned N = NREQ;

    always_comb begin
        logic        w_found;
        int unsigned w_pos;
        logic [PW-1:0] w_pos_idx;
        grant     = '0;
        idx       = '0;
        w_found   = 1'b0;
        w_pos     = 0;
        w_pos_idx = '0;
        // Walk ptr+1 .. ptr+N so the last winner gets lowest priority.
        for (int unsigned i = 1; i <= N; i++) begin
            w_pos     = (32'(ptr) + i) % N;
            w_pos_idx = PW'(w_pos);
            if (!w_found && req[w_pos_idx]) begin
                w_found          = 1'b1;
                idx              = w_pos_idx;
                grant[w_pos_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/msg_tx_scheduler.sv
// Arbitrates outbound FIX message requests and sequences one message at a
// time through the create-message FSM with a per-message watchdog.
`ifndef HOST_ADDR_WIDTH
`define HOST_ADDR_WIDTH 8
`endif

module msg_tx_scheduler
    import msg_tx_scheduler_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int HW      = `HOST_ADDR_WIDTH,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_i,
    input  logic [4*NREQ-1:0]  req_type_i,
    input  logic [HW*NREQ-1:0] req_host_i,
    input  logic               end_i,
    output logic [NREQ-1:0]    ack_o,
    output logic               start_o,
    output logic [3:0]         message_type_o,
    output logic [HW-1:0]      host_addr_o,
    output logic               busy_o,
    output logic               timeout_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    tx_state_t       r_state;
    tx_state_t       w_state_nxt;
    logic [PW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;
    logic [NREQ-1:0] r_ack;
    logic            r_start;
    logic            r_busy;
    logic            r_timeout;
    logic [3:0]      r_msg_type;
    logic [HW-1:0]   r_host;

    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_idx;
    logic            w_any;
    logic [3:0]      w_sel_type;
    logic [HW-1:0]   w_sel_host;
    logic            w_expire;
    logic            w_load;
    logic [NREQ-1:0] w_ack_nxt;
    logic            w_start_nxt;
    logic            w_busy_nxt;
    logic            w_timeout_nxt;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req   (req_i),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx)
    );

    assign w_any    = |req_i;
    assign w_expire = (r_cnt == CNT_LAST);

    always_comb begin
        w_sel_type = '0;
        w_sel_host = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_sel_type |= req_type_i[4*k +: 4] & {4{w_grant[k]}};
            w_sel_host |= req_host_i[HW*k +: HW] & {HW{w_grant[k]}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any) w_state_nxt = msg_is_valid(w_sel_type) ? ST_ISSUE : ST_GAP;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (end_i || w_expire) w_state_nxt = ST_GAP;
            ST_GAP:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are computed one cycle early so every port comes from a flop.
    always_comb begin
        w_load        = (r_state == ST_IDLE) && w_any;
        w_ack_nxt     = w_load ? w_grant : '0;
        w_start_nxt   = (w_state_nxt == ST_ISSUE);
        w_busy_nxt    = (w_state_nxt != ST_IDLE);
        w_timeout_nxt = (r_state == ST_WAIT) && !end_i && w_expire;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr      <= PW'(NREQ - 1);
            r_cnt      <= '0;
            r_ack      <= '0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_msg_type <= '0;
            r_host     <= '0;
        end else begin
            r_ack     <= w_ack_nxt;
            r_start   <= w_start_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
            if (w_load) begin
                r_ptr      <= w_idx;
                r_msg_type <= w_sel_type;
                r_host     <= w_sel_host;
            end
            if (r_state == ST_ISSUE)
                r_cnt <= '0;
            else if (r_state == ST_WAIT && r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign ack_o          = r_ack;
    assign start_o        = r_start;
    assign busy_o         = r_busy;
    assign timeout_o      = r_timeout;
    assign message_type_o = r_msg_type;
    assign host_addr_o    = r_host;

endmodule
